// File: rtl/booth_product_accumulator.sv
// Saturating product accumulator fed by the Booth multiplier over valid/ready.
// Sums a programmed number of signed products and pulses done with the final value.
module booth_product_accumulator #(
  parameter int unsigned PROD_W = 32,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_sub,
  output logic              prod_ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     acc_ext;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sum_sat;
  logic               sat_evt;

  // One guard bit keeps both +/- of the most negative product exact.
  always_comb begin
    prod_ext = {{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod};
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    sum      = prod_sub ? (acc_ext - prod_ext) : (acc_ext + prod_ext);
    sat_evt  = sum[ACC_W] != sum[ACC_W-1];
    if (!sat_evt) begin
      sum_sat = sum[ACC_W-1:0];
    end else if (sum[ACC_W]) begin
      sum_sat = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      sum_sat = {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            count_d = len;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (prod_valid) begin
          acc_d   = sum_sat;
          ovf_d   = ovf_q | sat_evt;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign prod_ready = (state_q == StRun);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

endmodule
